serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial N-bit unsigned subtractor built around the half/full subtractor cells already in the subtractor library.
- Processes one bit per clock, LSB first, and carries the borrow between bits in a single flop.
- Sits downstream of operand registers and produces a registered difference plus final borrow.
- Used where area matters more than latency; it is the sequential consumer of the combinational difference/borrow logic.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 1..32)

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous reset, active-high
start  input  1  request to begin a subtraction; sampled on rising clk edge
a  input  WIDTH  minuend; sampled only on the edge where start is accepted
b  input  WIDTH  subtrahend; sampled only on the edge where start is accepted
busy  output  1  high while an operation is in progress (states SHIFT and DONE)
done  output  1  one-cycle pulse; diff and bout are valid during it
diff  output  WIDTH  registered result, (a - b) mod 2^WIDTH
bout  output  1  registered final borrow; 1 when a < b (unsigned)

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset, asynchronous and effective immediately:
  - state = IDLE; busy = 0; done = 0; diff = 0; bout = 0.
  - Internal shift registers, borrow flop and bit counter are cleared.
- State IDLE:
  - busy = 0, done = 0.
  - If start = 1 on an edge: latch a and b into internal shift registers, clear the borrow flop, set count = 0, go to SHIFT.
  - Otherwise stay in IDLE.
- State SHIFT, one bit per edge:
  - ai = LSB of the a register; bi = LSB of the b register; br = borrow flop.
  - d = ai ^ bi ^ br.
  - br_next = (~ai & bi) | (~(ai ^ bi) & br).
  - Shift the a and b registers right by 1; shift d into the MSB of the internal result register; borrow flop <= br_next; count <= count + 1.
  - On the edge that processes bit WIDTH-1, go to DONE.
  - On that same edge, diff <= completed result (including this final bit) and bout <= br_next.
- State DONE:
  - Lasts exactly one cycle with done = 1 and busy = 1.
  - Next edge goes to IDLE unconditionally.
- Latency:
  - Accepting start on edge E gives done = 1 in the cycle following edge E+WIDTH.
  - start-to-done is WIDTH+1 edges.
  - Minimum spacing between accepted starts is WIDTH+2 cycles.
- Output hold:
  - diff and bout change only on the transition into DONE or on reset.
  - They hold their last result through IDLE and through the next operation's SHIFT cycles.
- start handling:
  - start is ignored in SHIFT and DONE; no queuing.
  - Operand changes on a or b while busy have no effect.
  - If start is held continuously high, the next operation is accepted on the first edge in IDLE, i.e. the edge after the DONE cycle.
- Counter: sized to hold values 0..WIDTH-1; no wrap-around reachable.
- WIDTH = 1: SHIFT lasts one edge; diff = a ^ b, bout = ~a & b.
- Reset mid-operation: abort at once; no done pulse; outputs go to their reset values.
- done and busy are registered outputs, with no combinational path from start.

Test Plan:
- Reset: assert rst asynchronously between edges -> busy = 0, done = 0, diff = 0x00, bout = 0 immediately, without waiting for a clk edge.
- Basic subtraction, WIDTH = 8: a = 0x35, b = 0x12, start accepted on edge E -> done = 1 only in the cycle after edge E+8, diff = 0x23, bout = 0, busy high for 9 cycles.
- Underflow cases:
  - a = 0x12, b = 0x35 -> diff = 0xDD, bout = 1.
  - a = 0x00, b = 0x01 -> diff = 0xFF, bout = 1.
  - a = b = 0xAA -> diff = 0x00, bout = 0.
  - a = 0xFF, b = 0x00 -> diff = 0xFF, bout = 0.
- Ignored start:
  - Start op a = 0x50, b = 0x20; pulse start at bit 3 with a = 0x01, b = 0x02 -> single done, diff = 0x30, bout = 0.
  - Then hold start high with a = 0x01, b = 0x02 -> second op accepted on the edge after done; its done gives diff = 0xFF, bout = 1.
  - diff stays 0x30 until that second done.
- Reset mid-operation: assert rst after 4 SHIFT edges of a = 0x80, b = 0x01 -> outputs cleared, no done pulse. Release rst, start a = 0x80, b = 0x01 -> diff = 0x7F, bout = 0.
- WIDTH = 1 instance: all four (a, b) combinations -> (diff, bout) = (0,0), (1,1), (1,0), (0,0), each with done 2 edges after start.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - operand/result bundle for the bit-serial subtractor
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    // Requester side: issues operands, observes status and result
    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  diff,
        input  bout
    );

    // Subtractor side: consumes operands, produces status and result
    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output diff,
        output bout
    );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, LSB first, one bit per clock
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor_if.slave   bus
);
    // Counter only needs to reach WIDTH-1; keep at least one bit for WIDTH = 1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_nxt;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    count;
    logic             br;
    logic             br_nxt;
    logic             bout_q;
    logic             busy_q;
    logic             done_q;
    logic             ai;
    logic             bi;
    logic             d;
    logic             last;

    // Full-subtractor cell on the current LSBs plus the running borrow
    always_comb begin
        ai      = a_sr[0];
        bi      = b_sr[0];
        d       = ai ^ bi ^ br;
        br_nxt  = (~ai & bi) | (~(ai ^ bi) & br);
        // New bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
        res_nxt = WIDTH'({d, res_sr} >> 1);
        last    = (count == LAST_BIT);
    end

    // Next-state decode; start is only honoured in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.start) state_nxt = ST_SHIFT;
            ST_SHIFT: if (last)      state_nxt = ST_DONE;
            ST_DONE:                 state_nxt = ST_IDLE;
            default:                 state_nxt = ST_IDLE;
        endcase
    end

    // State register with busy/done registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_q <= (state_nxt != ST_IDLE);
            done_q <= (state_nxt == ST_DONE);
        end
    end

    // Operand shifting, borrow chain and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            count  <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_sr   <= bus.a;
                        b_sr   <= bus.b;
                        res_sr <= '0;
                        br     <= 1'b0;
                        count  <= '0;
                    end
                end
                ST_SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_nxt;
                    br     <= br_nxt;
                    if (!last) begin
                        count <= count + 1'b1;
                    end else begin
                        // Published result only moves here, so it holds through idle and the next op.
                        diff_q <= res_nxt;
                        bout_q <= br_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed self-checking bench for serial_subtractor (WIDTH 8 and 1)
module tb_serial_subtractor;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    serial_subtractor_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_if #(.WIDTH(1)) bus1 ();

    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Count negedge samples until done on the 8-bit DUT; n = 0 means it never came.
    task automatic wait_done8(input int limit, output int n, output int nbusy);
        bit found;
        found = 0;
        n     = 0;
        nbusy = 0;
        while (!found && n < limit) begin
            @(negedge clk);
            n++;
            if (bus8.busy) nbusy++;
            if (bus8.done) found = 1;
        end
        if (!found) n = 0;
    endtask

    task automatic wait_done1(input int limit, output int n, output int nbusy);
        bit found;
        found = 0;
        n     = 0;
        nbusy = 0;
        while (!found && n < limit) begin
            @(negedge clk);
            n++;
            if (bus1.busy) nbusy++;
            if (bus1.done) found = 1;
        end
        if (!found) n = 0;
    endtask

    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ed, input logic eb);
        int n;
        int nb;
        @(posedge clk);
        #1;
        bus8.start = 1'b1;
        bus8.a     = a;
        bus8.b     = b;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        bus8.a     = ~a;
        bus8.b     = ~b;
        wait_done8(30, n, nb);
        check({tag, "_latency"}, n, 9);
        check({tag, "_busy_cycles"}, nb, 9);
        check({tag, "_diff"}, bus8.diff, ed);
        check({tag, "_bout"}, bus8.bout, eb);
        @(negedge clk);
        check({tag, "_done_fall"}, bus8.done, 0);
        check({tag, "_busy_fall"}, bus8.busy, 0);
    endtask

    task automatic run1(input string tag, input logic a, input logic b,
                        input logic ed, input logic eb);
        int n;
        int nb;
        @(posedge clk);
        #1;
        bus1.start = 1'b1;
        bus1.a     = a;
        bus1.b     = b;
        @(posedge clk);
        #1;
        bus1.start = 1'b0;
        wait_done1(10, n, nb);
        check({tag, "_latency"}, n, 2);
        check({tag, "_diff"}, bus1.diff, ed);
        check({tag, "_bout"}, bus1.bout, eb);
        @(negedge clk);
        check({tag, "_busy_fall"}, bus1.busy, 0);
    endtask

    initial begin
        int  n;
        int  nb;
        int  ndone;
        bit  held;
        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b0;
        bus8.start = 1'b0;
        bus8.a     = '0;
        bus8.b     = '0;
        bus1.start = 1'b0;
        bus1.a     = '0;
        bus1.b     = '0;

        // Asynchronous reset between edges
        #3;
        rst = 1'b1;
        #1;
        check("rst_busy", bus8.busy, 0);
        check("rst_done", bus8.done, 0);
        check("rst_diff", bus8.diff, 8'h00);
        check("rst_bout", bus8.bout, 0);
        check("rst1_busy", bus1.busy, 0);
        check("rst1_diff", bus1.diff, 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        run8("basic",  8'h35, 8'h12, 8'h23, 1'b0);
        run8("under1", 8'h12, 8'h35, 8'hDD, 1'b1);
        run8("under2", 8'h00, 8'h01, 8'hFF, 1'b1);
        run8("equal",  8'hAA, 8'hAA, 8'h00, 1'b0);
        run8("max",    8'hFF, 8'h00, 8'hFF, 1'b0);

        // Start pulsed mid-operation must be ignored
        @(posedge clk);
        #1;
        bus8.start = 1'b1;
        bus8.a     = 8'h50;
        bus8.b     = 8'h20;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("ign_hold_prev", bus8.diff, 8'hFF);
        bus8.start = 1'b1;
        bus8.a     = 8'h01;
        bus8.b     = 8'h02;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        wait_done8(30, n, nb);
        check("ign_latency", n, 5);
        check("ign_diff", bus8.diff, 8'h30);
        check("ign_bout", bus8.bout, 0);

        // Start held high from the DONE cycle: next op accepted on the edge after DONE
        bus8.start = 1'b1;
        bus8.a     = 8'h01;
        bus8.b     = 8'h02;
        held       = 1;
        n          = 0;
        while (n < 30) begin
            @(negedge clk);
            n++;
            if (bus8.done) break;
            if (bus8.diff !== 8'h30) held = 0;
        end
        bus8.start = 1'b0;
        check("hold_spacing", n, 10);
        check("hold_diff_kept", held, 1);
        check("hold_diff", bus8.diff, 8'hFF);
        check("hold_bout", bus8.bout, 1);
        @(negedge clk);
        check("hold_busy_fall", bus8.busy, 0);

        // Reset in the middle of an operation
        @(posedge clk);
        #1;
        bus8.start = 1'b1;
        bus8.a     = 8'h80;
        bus8.b     = 8'h01;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", bus8.busy, 0);
        check("mid_rst_done", bus8.done, 0);
        check("mid_rst_diff", bus8.diff, 8'h00);
        check("mid_rst_bout", bus8.bout, 0);
        repeat (2) @(posedge clk);
        #2;
        rst   = 1'b0;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus8.done) ndone++;
        end
        check("mid_rst_no_done", ndone, 0);
        run8("after_rst", 8'h80, 8'h01, 8'h7F, 1'b0);

        // Single-bit instance, all four operand combinations
        run1("w1_00", 1'b0, 1'b0, 1'b0, 1'b0);
        run1("w1_01", 1'b0, 1'b1, 1'b1, 1'b1);
        run1("w1_10", 1'b1, 1'b0, 1'b1, 1'b0);
        run1("w1_11", 1'b1, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
